// File: rtl/npsg_wave_sched.sv
// Shares one synchronous wave ROM among NV PSG voices: each sample tick snapshots the
// requesting voices and reads their nibbles back-to-back in ascending voice order.
module npsg_wave_sched #(
    parameter int NV      = 3,
    parameter int AW      = 8,
    parameter int DW      = 4,
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [NV-1:0]    req,
    input  logic [NV*AW-1:0] req_addr,
    output logic             rom_en,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic [NV*DW-1:0] voice_data,
    output logic [NV-1:0]    voice_vld,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int IW = (NV > 1) ? $clog2(NV) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e           state_q;
    logic [NV-1:0]    pend_q;
    logic [AW-1:0]    snap_q [NV];
    logic             rom_en_q;
    logic [AW-1:0]    rom_addr_q;
    logic [ROM_LAT:0] pv_q;
    logic [IW-1:0]    ptag_q [ROM_LAT+1];
    logic [NV*DW-1:0] vdata_q;
    logic [NV-1:0]    vld_q;
    logic             busy_q;
    logic             ovr_q;

    logic             start;
    logic [NV-1:0]    src_mask;
    logic [NV-1:0]    pend_d;
    logic             issue;
    logic [IW-1:0]    sel_idx;
    logic [AW-1:0]    sel_addr;

    // The first voice of a frame is issued on the tick edge itself, straight from
    // the live inputs; later voices come from the snapshot.
    always_comb begin
        start    = (state_q == IDLE) && tick && (req != '0);
        src_mask = '0;
        if (start) begin
            src_mask = req;
        end else if (state_q == ISSUE) begin
            src_mask = pend_q;
        end
        issue   = (src_mask != '0);
        sel_idx = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                sel_idx = IW'(i);
            end
        end
        if (start) begin
            sel_addr = req_addr[int'(sel_idx)*AW +: AW];
        end else begin
            sel_addr = snap_q[sel_idx];
        end
        pend_d = src_mask;
        if (issue) begin
            pend_d[sel_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            pv_q       <= '0;
            vdata_q    <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            for (int i = 0; i < NV; i++) begin
                snap_q[i] <= '0;
            end
            for (int j = 0; j <= ROM_LAT; j++) begin
                ptag_q[j] <= '0;
            end
        end else begin
            rom_en_q <= issue;
            if (issue) begin
                rom_addr_q <= sel_addr;
            end

            // Tag pipe: stage j lines up with the cycle j after the ROM saw rom_en.
            pv_q      <= {pv_q[ROM_LAT-1:0], issue};
            ptag_q[0] <= sel_idx;
            for (int j = 1; j <= ROM_LAT; j++) begin
                ptag_q[j] <= ptag_q[j-1];
            end

            if (pv_q[ROM_LAT]) begin
                vdata_q[int'(ptag_q[ROM_LAT])*DW +: DW] <= rom_data;
                vld_q <= NV'(1) << ptag_q[ROM_LAT];
            end else begin
                vld_q <= '0;
            end

            if (tick && busy_q) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NV; i++) begin
                            snap_q[i] <= req_addr[i*AW +: AW];
                        end
                        pend_q  <= pend_d;
                        busy_q  <= 1'b1;
                        state_q <= (pend_d == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    pend_q <= pend_d;
                    if (pend_d == '0) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pv_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign voice_data = vdata_q;
    assign voice_vld  = vld_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_npsg_wave_sched.sv
// Directed bench for npsg_wave_sched: one ROM_LAT=1 instance and one ROM_LAT=2
// instance share stimulus; each has its own ROM returning addr[3:0]^4'hA.
module tb_npsg_wave_sched;

    localparam int NV = 3;
    localparam int AW = 8;
    localparam int DW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic             clr_ovr = 1'b0;
    logic [NV-1:0]    req = '0;
    logic [NV*AW-1:0] req_addr = '0;

    logic             rom_en, rom_en2;
    logic [AW-1:0]    rom_addr, rom_addr2;
    logic [DW-1:0]    rom_data, rom_data2;
    logic [NV*DW-1:0] voice_data, voice_data2;
    logic [NV-1:0]    voice_vld, voice_vld2;
    logic             busy, busy2, overrun, overrun2;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs and ROM models ----------------
    npsg_wave_sched #(.NV(NV), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .req_addr(req_addr),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .voice_data(voice_data), .voice_vld(voice_vld), .busy(busy),
        .overrun(overrun), .clr_ovr(clr_ovr)
    );

    npsg_wave_sched #(.NV(NV), .AW(AW), .DW(DW), .ROM_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .req_addr(req_addr),
        .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .voice_data(voice_data2), .voice_vld(voice_vld2), .busy(busy2),
        .overrun(overrun2), .clr_ovr(clr_ovr)
    );

    logic [DW-1:0] rom2_s1 = '0;
    initial rom_data  = '0;
    initial rom_data2 = '0;
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_addr[3:0] ^ 4'hA;
        if (rom_en2) rom2_s1 <= rom_addr2[3:0] ^ 4'hA;
        rom_data2 <= rom2_s1;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned in cycle T+1 (just after the edge that sampled the tick).
    task automatic start_frame(input logic [NV-1:0] r, input logic [7:0] a0, a1, a2);
        req      = r;
        req_addr = {a2, a1, a0};
        tick     = 1'b1;
        step();
        tick     = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%0b exp=0", rom_en); end
        checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
        checks++; if (voice_data !== 12'h000) begin failures++; $display("FAIL reset_voice_data got=%h exp=000", voice_data); end
        checks++; if (voice_vld !== 3'b000) begin failures++; $display("FAIL reset_vld got=%b exp=000", voice_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        logic [5:0] en_m   = 6'b000111;
        logic [5:0] busy_m = 6'b011111;
        logic [2:0] vld_e [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
        logic [AW-1:0] e;
        exp_q = {8'h12, 8'h45, 8'h78};
        start_frame(3'b111, 8'h12, 8'h45, 8'h78);
        for (int c = 0; c < 6; c++) begin
            checks++; if (rom_en !== en_m[c]) begin failures++; $display("FAIL full_rom_en c=T+%0d got=%0b exp=%0b", c+1, rom_en, en_m[c]); end
            if (rom_en === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++; if (rom_addr !== e) begin failures++; $display("FAIL full_rom_addr c=T+%0d got=%h exp=%h", c+1, rom_addr, e); end
            end
            checks++; if (voice_vld !== vld_e[c]) begin failures++; $display("FAIL full_vld c=T+%0d got=%b exp=%b", c+1, voice_vld, vld_e[c]); end
            checks++; if (busy !== busy_m[c]) begin failures++; $display("FAIL full_busy c=T+%0d got=%0b exp=%0b", c+1, busy, busy_m[c]); end
            step();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_issue_count left=%0d exp=0", exp_q.size()); end
        checks++; if (voice_data !== 12'h2F8) begin failures++; $display("FAIL full_voice_data got=%h exp=2f8", voice_data); end
    endtask

    task automatic test_partial();
        logic [4:0] en_m   = 5'b00011;
        logic [4:0] busy_m = 5'b01111;
        logic [2:0] vld_e [5] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b000};
        logic [AW-1:0] e;
        step();
        exp_q = {8'h33, 8'h5C};
        start_frame(3'b101, 8'h33, 8'h99, 8'h5C);
        for (int c = 0; c < 5; c++) begin
            checks++; if (rom_en !== en_m[c]) begin failures++; $display("FAIL part_rom_en c=T+%0d got=%0b exp=%0b", c+1, rom_en, en_m[c]); end
            if (rom_en === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++; if (rom_addr !== e) begin failures++; $display("FAIL part_rom_addr c=T+%0d got=%h exp=%h", c+1, rom_addr, e); end
            end
            checks++; if (voice_vld !== vld_e[c]) begin failures++; $display("FAIL part_vld c=T+%0d got=%b exp=%b", c+1, voice_vld, vld_e[c]); end
            checks++; if (busy !== busy_m[c]) begin failures++; $display("FAIL part_busy c=T+%0d got=%0b exp=%0b", c+1, busy, busy_m[c]); end
            step();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL part_issue_count left=%0d exp=0", exp_q.size()); end
        checks++; if (voice_data !== 12'h6F9) begin failures++; $display("FAIL part_voice_data got=%h exp=6f9", voice_data); end
    endtask

    task automatic test_no_req();
        step();
        start_frame(3'b000, 8'hAA, 8'hBB, 8'hCC);
        for (int c = 0; c < 4; c++) begin
            checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL noreq_rom_en c=T+%0d got=%0b exp=0", c+1, rom_en); end
            checks++; if (voice_vld !== 3'b000) begin failures++; $display("FAIL noreq_vld c=T+%0d got=%b exp=000", c+1, voice_vld); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noreq_busy c=T+%0d got=%0b exp=0", c+1, busy); end
            step();
        end
        checks++; if (rom_addr !== 8'h5C) begin failures++; $display("FAIL noreq_addr_hold got=%h exp=5c", rom_addr); end
        checks++; if (voice_data !== 12'h6F9) begin failures++; $display("FAIL noreq_voice_data got=%h exp=6f9", voice_data); end
    endtask

    task automatic test_overrun();
        logic [6:0] en_m   = 7'b0000111;
        logic [6:0] busy_m = 7'b0011111;
        logic [6:0] ovr_m  = 7'b1111100;
        logic [2:0] vld_e [7] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        step();
        start_frame(3'b111, 8'h01, 8'h02, 8'h03);
        for (int c = 0; c < 7; c++) begin
            checks++; if (rom_en !== en_m[c]) begin failures++; $display("FAIL ovr_rom_en c=T+%0d got=%0b exp=%0b", c+1, rom_en, en_m[c]); end
            checks++; if (voice_vld !== vld_e[c]) begin failures++; $display("FAIL ovr_vld c=T+%0d got=%b exp=%b", c+1, voice_vld, vld_e[c]); end
            checks++; if (busy !== busy_m[c]) begin failures++; $display("FAIL ovr_busy c=T+%0d got=%0b exp=%0b", c+1, busy, busy_m[c]); end
            checks++; if (overrun !== ovr_m[c]) begin failures++; $display("FAIL ovr_flag c=T+%0d got=%0b exp=%0b", c+1, overrun, ovr_m[c]); end
            if (c == 1) tick = 1'b1;
            step();
            tick = 1'b0;
        end
        checks++; if (voice_data !== 12'h98B) begin failures++; $display("FAIL ovr_voice_data got=%h exp=98b", voice_data); end
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
        start_frame(3'b111, 8'h01, 8'h02, 8'h03);
        step();
        tick    = 1'b1;
        clr_ovr = 1'b1;
        step();
        tick    = 1'b0;
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", overrun); end
        repeat (5) step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_idle_after got=%0b exp=0", busy); end
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
    endtask

    task automatic test_snapshot();
        logic [AW-1:0] e;
        step();
        exp_q = {8'h24, 8'h36, 8'h4F};
        start_frame(3'b111, 8'h24, 8'h36, 8'h4F);
        req_addr = {8'hFF, 8'hEE, 8'hDD};
        req      = 3'b000;
        for (int c = 0; c < 6; c++) begin
            if (rom_en === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++; if (rom_addr !== e) begin failures++; $display("FAIL snap_rom_addr c=T+%0d got=%h exp=%h", c+1, rom_addr, e); end
            end
            step();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL snap_issue_count left=%0d exp=0", exp_q.size()); end
        checks++; if (voice_data !== 12'h5CE) begin failures++; $display("FAIL snap_voice_data got=%h exp=5ce", voice_data); end
    endtask

    task automatic test_reset_mid();
        step();
        start_frame(3'b111, 8'h0A, 8'h0B, 8'h0C);
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL rmid_rom_en got=%0b exp=0", rom_en); end
        checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL rmid_rom_addr got=%h exp=00", rom_addr); end
        checks++; if (voice_data !== 12'h000) begin failures++; $display("FAIL rmid_voice_data got=%h exp=000", voice_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (voice_vld !== 3'b000) begin failures++; $display("FAIL rmid_vld c=%0d got=%b exp=000", c, voice_vld); end
            checks++; if (rom_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_quiet c=%0d got=%0b%0b exp=00", c, rom_en, busy); end
        end
        checks++; if (voice_data !== 12'h000) begin failures++; $display("FAIL rmid_data_after got=%h exp=000", voice_data); end
    endtask

    task automatic test_rom_lat2();
        logic [6:0] en_m   = 7'b0000111;
        logic [6:0] busy_m = 7'b0111111;
        logic [2:0] vld_e [7] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
        logic [AW-1:0] e;
        step();
        exp_q = {8'h12, 8'h45, 8'h78};
        start_frame(3'b111, 8'h12, 8'h45, 8'h78);
        for (int c = 0; c < 7; c++) begin
            checks++; if (rom_en2 !== en_m[c]) begin failures++; $display("FAIL lat2_rom_en c=T+%0d got=%0b exp=%0b", c+1, rom_en2, en_m[c]); end
            if (rom_en2 === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++; if (rom_addr2 !== e) begin failures++; $display("FAIL lat2_rom_addr c=T+%0d got=%h exp=%h", c+1, rom_addr2, e); end
            end
            checks++; if (voice_vld2 !== vld_e[c]) begin failures++; $display("FAIL lat2_vld c=T+%0d got=%b exp=%b", c+1, voice_vld2, vld_e[c]); end
            checks++; if (busy2 !== busy_m[c]) begin failures++; $display("FAIL lat2_busy c=T+%0d got=%0b exp=%0b", c+1, busy2, busy_m[c]); end
            step();
        end
        checks++; if (voice_data2 !== 12'h2F8) begin failures++; $display("FAIL lat2_voice_data got=%h exp=2f8", voice_data2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_frame();
        test_partial();
        test_no_req();
        test_overrun();
        test_snapshot();
        test_reset_mid();
        test_rom_lat2();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npsg_wave_sched.md
Name: npsg_wave_sched

Overview:
- Time-multiplexes one shared synchronous 4-bit wave ROM among NV wave-table voices of the PSG.
- On each sample tick it snapshots every requesting voice's wave address and issues those addresses to the ROM back-to-back, in ascending voice order.
- It captures the returned nibbles into per-voice hold registers and pulses a per-voice valid strobe.
- It replaces the free-running phase-counter ROM multiplexing in the sound block with a deterministic, handshaked schedule.

Parameters:
- NV, 3, number of voices sharing the ROM (1..8).
- AW, 8, wave ROM address width ({voice_wave_sel[2:0], phase[4:0]}).
- DW, 4, wave ROM data width.
- ROM_LAT, 1, cycles from rom_en/rom_addr valid to rom_data valid (1 or 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle sample strobe; starts a frame.
- req  in  NV  per-voice request level, sampled at tick.
- req_addr  in  NV*AW  per-voice ROM address; voice i at [i*AW +: AW], sampled at tick.
- rom_en  out  1  ROM read enable; registered.
- rom_addr  out  AW  ROM address; registered.
- rom_data  in  DW  ROM read data, ROM_LAT cycles after rom_en.
- voice_data  out  NV*DW  per-voice held wave nibble.
- voice_vld  out  NV  one-cycle pulse when voice_data[i] updates.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: tick arrived while busy.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst_n=0): rom_en=0, rom_addr=0, voice_data=0, voice_vld=0, busy=0, overrun=0, pending mask=0, latency pipe cleared. Reset mid-frame abandons the frame; no vld is produced after rst_n deasserts until a new tick.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE behaviour:
  - On tick with req!=0: latch pend<=req and all req_addr into snapshot registers, set busy=1, go to ISSUE.
  - On tick with req==0: stay IDLE, busy stays 0, no ROM cycle, no vld.
- ISSUE behaviour:
  - Each cycle, select the lowest-index set bit k of pend.
  - Drive rom_en=1 and rom_addr=snap_addr[k] (registered, visible the cycle after selection).
  - Clear pend[k] and push tag k into a ROM_LAT-deep tag pipe.
  - When pend becomes 0, go to DRAIN. Issues are back-to-back with no bubbles.
- DRAIN behaviour: rom_en=0, rom_addr holds its last value. When the tag pipe is empty, go to IDLE and set busy=0 on the same edge.
- Capture: in the cycle ROM_LAT after an issue cycle, sample rom_data into voice_data[tag]. voice_vld[tag]=1 in the following cycle only. At most one vld bit is high per cycle.
- Timing with ROM_LAT=1 and tick sampled at edge T, for n requesting voices:
  - rom_en high in cycles T+1..T+n.
  - vld pulses in cycles T+3..T+n+2.
  - busy high from T+1 through T+n+2 inclusive.
- Non-requesting voices keep their voice_data unchanged and get no vld.
- Snapshot isolation: req/req_addr changes after the tick edge do not affect the current frame.
- Overrun: a tick while busy=1 is dropped and sets overrun=1; the frame in progress continues unaffected.
  - clr_ovr=1 clears overrun.
  - Simultaneous clr_ovr and a dropped tick leaves overrun=1 (set wins).
- rom_addr changes only on issue cycles.

Test Plan:
- Reset then tick, req=3'b111, addrs 0x12/0x45/0x78, ROM returns a[3:0]^4'hA: rom_en in T+1..T+3 with addrs 0x12, 0x45, 0x78; vld 001, 010, 100 in T+3..T+5; voice_data = 8, F, 2; busy low at T+6.
- tick, req=3'b101: only addrs of voices 0 and 2 issued, in 2 consecutive cycles; voice1 data holds its old value; busy high 4 cycles.
- tick with req=0: no rom_en, no vld, busy stays 0.
- Second tick at T+2 of a full frame: frame completes normally, overrun=1. clr_ovr pulse returns overrun to 0. Simultaneous clr_ovr and dropped tick leaves overrun=1.
- Change req_addr at T+1 during a frame: issued addresses equal the values sampled at the tick.
- rst_n low at T+2, then high: all outputs 0, no further vld. ROM_LAT=2 build: vld shifted one cycle later, busy one cycle longer.
